ram_req_ctrl: RTL and testbench
===============================

Name: ram_req_ctrl

Overview:
- Upstream neighbour of the PSRAM interface block; converts the CPU-side memory request handshake into the level-held `ram_read`/`ram_write` strobes that block expects.
- The PSRAM block double-synchronises the strobes into its own clock. It needs each strobe held for a minimum time, then deasserted for a minimum time, before the next command.
- Adds a single-entry posted-write buffer so CPU writes acknowledge early. Reads are strictly ordered behind any buffered write.

Parameters:
- RD_HOLD, 16, mclk cycles `ram_read` stays high; `ram_rdata` is sampled on the last cycle.
- WR_HOLD, 16, mclk cycles `ram_write` stays high.
- RECOVER, 4, mclk cycles both strobes stay low after any command (must cover the 2-flop sync plus 1).

Ports:
- mclk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- init  in  1  PSRAM calibration done; gates command start
- cpu_req  in  1  request valid, held until cpu_ack
- cpu_we  in  1  1=write, 0=read
- cpu_byte  in  1  byte access (lane from cpu_addr[0])
- cpu_addr  in  22  byte address
- cpu_wdata  in  16  write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  16  read data, valid with cpu_ack on reads, held until next read
- busy  out  1  engine not IDLE or write buffer occupied
- ram_read  out  1  read strobe to PSRAM block
- ram_write  out  1  write strobe to PSRAM block
- ram_byte  out  1  byte-write flag
- ram_addr  out  22  address to PSRAM block
- ram_wdata  out  16  write data to PSRAM block
- ram_rdata  in  16  read data from PSRAM block, stable once RD_HOLD elapses

Behaviour:
- Clock and reset:
  - Single clock `mclk`; reset `rst_n` is asynchronous, active-low.
  - Reset clears all outputs and state to 0: cpu_ack, cpu_rdata, busy, ram_read, ram_write, ram_byte, ram_addr, ram_wdata, wb_valid, counter; FSM goes to IDLE.
  - Reset mid-command drops the strobes immediately; the PSRAM block is reset by the same rst_n.
- Request acceptance (a request is "live" while cpu_req=1 and no ack has been issued for it):
  - Write, wb_valid=0: latch addr/wdata/byte into wb, set wb_valid, pulse cpu_ack next cycle.
  - Write, wb_valid=1: stall; acceptance uses wb_valid as registered, so a retire and an accept never happen in the same cycle.
  - Read: the engine takes it only when wb_valid=0 and FSM is IDLE.
  - The CPU may change request fields and keep cpu_req high on the cycle after cpu_ack. It is treated as a new request, with no ack in that cycle.
- Engine FSM: IDLE, RD, WR, RECOV.
  - IDLE:
    - If init=0, stay.
    - Else if wb_valid: load ram_addr/ram_wdata/ram_byte from wb, ram_write=1, cnt=WR_HOLD-1, go to WR.
    - Else if a read is live: ram_addr=cpu_addr, ram_byte=0, ram_read=1, cnt=RD_HOLD-1, go to RD.
    - A buffered write always beats a read.
  - RD: decrement cnt. At cnt=0: cpu_rdata<=ram_rdata, cpu_ack pulse, ram_read=0, cnt=RECOVER-1, go to RECOV.
  - WR: decrement cnt. At cnt=0: ram_write=0, clear wb_valid, cnt=RECOVER-1, go to RECOV.
  - RECOV: decrement cnt. At 0 go to IDLE; the earliest next command starts the following cycle.
- Strobe rules:
  - ram_read and ram_write are never high together.
  - ram_addr/ram_wdata/ram_byte are stable for the whole strobe and RECOV interval.
- init deassert mid-command: the in-flight command completes normally; no new command starts.
- Read-only byte: a byte read does a word read; the CPU selects the lane.
- Counter width: $clog2(max(RD_HOLD,WR_HOLD,RECOVER))+1.
- Latencies:
  - Read, idle engine: ack RD_HOLD+1 cycles after cpu_req rises.
  - Posted write: ack 1 cycle after acceptance.

Decomposition:
- Package ram_ctrl_pkg holds:
  - state typedef enum {IDLE,RD,WR,RECOV};
  - wb_entry_t struct {addr[21:0], data[15:0], byte};
  - default hold constants.
- One natural sub-module, ram_wbuf: the single-entry write buffer with push/pop/valid. Everything else stays in one module.

Test Plan:
- Read, idle, RD_HOLD=16, ram_rdata=16'hA5C3, addr 22'h000100 -> ram_read high exactly 16 cycles with ram_addr=22'h000100; cpu_ack pulses once with cpu_rdata=16'hA5C3; strobes low for 4 cycles after.
- Word write 16'h1234 @22'h000200 -> cpu_ack on cycle 2; ram_write high 16 cycles with ram_byte=0; busy deasserts after RECOV.
- Write @22'h000300 immediately followed by read @22'h000300 -> read's ram_read rises only after write's RECOV completes; no overlap of strobes.
- Two back-to-back writes -> second ack delayed until first write retires (≥ WR_HOLD cycles); wb contents of first unchanged on ram_wdata during its strobe.
- init=0 with pending read -> no strobe; raise init -> ram_read asserts next cycle.
- rst_n low mid-WR (cycle 8) -> ram_write, busy, wb_valid drop asynchronously to 0; after release FSM is IDLE and a new read completes normally.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared types and default timing for the CPU-to-PSRAM request controller.
// Hold/recovery counts are in mclk cycles.
package ram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        WR    = 2'd2,
        RECOV = 2'd3
    } state_t;

    // 'byte' is a keyword, so the byte-access flag is named is_byte
    typedef struct packed {
        logic [21:0] addr;
        logic [15:0] data;
        logic        is_byte;
    } wb_entry_t;

    localparam int RD_HOLD_DEF = 16;
    localparam int WR_HOLD_DEF = 16;
    localparam int RECOVER_DEF = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ram_wbuf.sv
// Single-entry posted-write buffer.
// The caller only pushes when empty and only pops when full.
module ram_wbuf
    import ram_ctrl_pkg::*;
(
    input  logic      mclk,
    input  logic      rst_n,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t din,
    output wb_entry_t dout,
    output logic      valid
);

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (push) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ram_req_ctrl.sv
// Turns the CPU request/ack handshake into level-held ram_read/ram_write strobes
// with minimum hold and recovery times; writes are posted through ram_wbuf.
//
// state | meaning
// IDLE  | no command on the strobes; may start a buffered write or a live read
// RD    | ram_read held, counting down RD_HOLD
// WR    | ram_write held, counting down WR_HOLD
// RECOV | both strobes low, counting down RECOVER
module ram_req_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int RD_HOLD = RD_HOLD_DEF,
    parameter int WR_HOLD = WR_HOLD_DEF,
    parameter int RECOVER = RECOVER_DEF
) (
    input  logic        mclk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic        cpu_byte,
    input  logic [21:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,
    output logic        busy,
    output logic        ram_read,
    output logic        ram_write,
    output logic        ram_byte,
    output logic [21:0] ram_addr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata
);

    localparam int CW = $clog2(max3(RD_HOLD, WR_HOLD, RECOVER)) + 1;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic           wb_valid;
    logic           wb_push;
    logic           wb_pop;
    logic           rd_live;
    wb_entry_t      wb_in;
    wb_entry_t      wb_out;

    // The cycle carrying cpu_ack never starts a new request, even with cpu_req held.
    assign rd_live = cpu_req && !cpu_we && !cpu_ack;
    assign wb_push = cpu_req && cpu_we && !cpu_ack && !wb_valid;
    assign wb_pop  = (state == WR) && (cnt == '0);
    assign busy    = (state != IDLE) || wb_valid;

    assign wb_in.addr    = cpu_addr;
    assign wb_in.data    = cpu_wdata;
    assign wb_in.is_byte = cpu_byte;

    ram_wbuf u_wbuf (
        .mclk  (mclk),
        .rst_n (rst_n),
        .push  (wb_push),
        .pop   (wb_pop),
        .din   (wb_in),
        .dout  (wb_out),
        .valid (wb_valid)
    );

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
            ram_read  <= 1'b0;
            ram_write <= 1'b0;
            ram_byte  <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            cpu_ack <= wb_push;
            case (state)
                IDLE: begin
                    if (init) begin
                        if (wb_valid) begin
                            ram_addr  <= wb_out.addr;
                            ram_wdata <= wb_out.data;
                            ram_byte  <= wb_out.is_byte;
                            ram_write <= 1'b1;
                            cnt       <= CW'(WR_HOLD - 1);
                            state     <= WR;
                        end else if (rd_live) begin
                            // byte reads fetch the whole word; the CPU picks the lane
                            ram_addr  <= cpu_addr;
                            ram_byte  <= 1'b0;
                            ram_read  <= 1'b1;
                            cnt       <= CW'(RD_HOLD - 1);
                            state     <= RD;
                        end
                    end
                end
                RD: begin
                    if (cnt == '0) begin
                        cpu_rdata <= ram_rdata;
                        cpu_ack   <= 1'b1;
                        ram_read  <= 1'b0;
                        cnt       <= CW'(RECOVER - 1);
                        state     <= RECOV;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WR: begin
                    if (cnt == '0) begin
                        ram_write <= 1'b0;
                        cnt       <= CW'(RECOVER - 1);
                        state     <= RECOV;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RECOV: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Bench for ram_req_ctrl: a timeline model (command start cycle plus fixed
// durations) is checked every cycle, alongside directed scenarios with literal expectations.
module tb_ram_req_ctrl;

    localparam int RD_HOLD = 16;
    localparam int WR_HOLD = 16;
    localparam int RECOVER = 4;

    logic        mclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic        cpu_byte = 1'b0;
    logic [21:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic [15:0] ram_rdata = '0;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic        busy;
    logic        ram_read;
    logic        ram_write;
    logic        ram_byte;
    logic [21:0] ram_addr;
    logic [15:0] ram_wdata;

    always #5 mclk = ~mclk;

    ram_req_ctrl #(.RD_HOLD(RD_HOLD), .WR_HOLD(WR_HOLD), .RECOVER(RECOVER)) dut (
        .mclk      (mclk),
        .rst_n     (rst_n),
        .init      (init),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_byte  (cpu_byte),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .busy      (busy),
        .ram_read  (ram_read),
        .ram_write (ram_write),
        .ram_byte  (ram_byte),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a command is (kind, start edge); outputs follow from elapsed edges.
    int          m_cycle = 0;
    int          kind = 0;
    int          start = 0;
    bit          m_ack = 1'b0;
    logic [15:0] m_rdata = '0;
    bit          wb_v = 1'b0;
    logic [21:0] wb_addr = '0;
    logic [15:0] wb_data = '0;
    bit          wb_byte = 1'b0;
    logic [21:0] m_addr = '0;
    logic [15:0] m_wdata = '0;
    bit          m_byte = 1'b0;

    function automatic int hold_of(input int k);
        return (k == 1) ? RD_HOLD : WR_HOLD;
    endfunction

    task automatic model_step();
        bit ack_p, wbv_p, ack_n, free;
        int kind_p, start_p, n;
        if (!rst_n) begin
            m_cycle = 0; kind = 0; start = 0; m_ack = 0; m_rdata = '0;
            wb_v = 0; wb_addr = '0; wb_data = '0; wb_byte = 0;
            m_addr = '0; m_wdata = '0; m_byte = 0;
            return;
        end
        m_cycle++;
        n = m_cycle;
        ack_p = m_ack; wbv_p = wb_v; kind_p = kind; start_p = start;
        ack_n = 0;
        if (kind_p == 1 && n == start_p + RD_HOLD) begin
            ack_n = 1;
            m_rdata = ram_rdata;
        end
        if (kind_p == 2 && n == start_p + WR_HOLD) wb_v = 0;
        if (cpu_req && cpu_we && !ack_p && !wbv_p) begin
            wb_addr = cpu_addr; wb_data = cpu_wdata; wb_byte = cpu_byte;
            wb_v = 1; ack_n = 1;
        end
        free = (kind_p == 0) || (n > start_p + hold_of(kind_p) + RECOVER);
        if (free && init) begin
            if (wbv_p) begin
                kind = 2; start = n;
                m_addr = wb_addr; m_wdata = wb_data; m_byte = wb_byte;
            end else if (cpu_req && !cpu_we && !ack_p) begin
                kind = 1; start = n;
                m_addr = cpu_addr; m_byte = 0;
            end
        end
        m_ack = ack_n;
    endtask

    initial forever begin
        @(posedge mclk);
        model_step();
    end

    // Strobe trackers feeding the directed checks.
    bit          pr_rd = 0, pr_wr = 0;
    int          rd_len = 0, wr_len = 0, last_rd_len = 0, last_wr_len = 0;
    int          low_run = 0, last_gap = 0;
    logic [21:0] rise_addr = '0;
    logic [15:0] rise_wdata = '0, fall_wdata = '0;
    bit          rise_byte = 0;

    initial forever begin
        bit e_rd, e_wr, e_busy;
        @(negedge mclk);
        if (rst_n) begin
            e_rd   = (kind == 1) && (m_cycle < start + RD_HOLD);
            e_wr   = (kind == 2) && (m_cycle < start + WR_HOLD);
            e_busy = wb_v || ((kind != 0) && (m_cycle < start + hold_of(kind) + RECOVER));
            chk("ram_read", ram_read, e_rd);
            chk("ram_write", ram_write, e_wr);
            chk("busy", busy, e_busy);
            chk("cpu_ack", cpu_ack, m_ack);
            chk("cpu_rdata", cpu_rdata, m_rdata);
            chk("strobe_excl", ram_read & ram_write, 0);
            if (kind != 0) begin
                chk("ram_addr", ram_addr, m_addr);
                chk("ram_byte", ram_byte, m_byte);
                if (kind == 2) chk("ram_wdata", ram_wdata, m_wdata);
            end
            if (ram_read) rd_len++;
            else if (pr_rd) begin last_rd_len = rd_len; rd_len = 0; end
            if (ram_write) begin wr_len++; fall_wdata = ram_wdata; end
            else if (pr_wr) begin last_wr_len = wr_len; wr_len = 0; end
            if (!ram_read && !ram_write) low_run++;
            else begin
                if (!pr_rd && !pr_wr) begin
                    last_gap = low_run;
                    rise_addr = ram_addr; rise_wdata = ram_wdata; rise_byte = ram_byte;
                end
                low_run = 0;
            end
            pr_rd = ram_read;
            pr_wr = ram_write;
        end else begin
            pr_rd = 0; pr_wr = 0; rd_len = 0; wr_len = 0; low_run = 0;
        end
    end

    task automatic do_req(input bit we, input bit by, input logic [21:0] a,
                          input logic [15:0] d, input bit keep, output int lat);
        cpu_req = 1; cpu_we = we; cpu_byte = by; cpu_addr = a; cpu_wdata = d;
        lat = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge mclk);
            #1;
            if (cpu_ack) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) chk("ack_timeout", lat, 1);
        if (!keep) cpu_req = 0;
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge mclk);
            #1;
            if (!busy && !cpu_ack) begin
                waited = i;
                break;
            end
        end
        if (waited == 0) chk("idle_timeout", waited, 1);
    endtask

    initial begin
        int lat, lat2, cnt_ok, hits;
        repeat (3) @(negedge mclk);
        chk("rst_busy", busy, 0);
        chk("rst_ram_read", ram_read, 0);
        chk("rst_ram_write", ram_write, 0);
        chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        rst_n = 1; init = 1;
        @(negedge mclk);

        // idle read
        ram_rdata = 16'hA5C3;
        do_req(0, 0, 22'h000100, 16'h0, 0, lat);
        chk("rd_lat", lat, 17);
        chk("rd_data", cpu_rdata, 16'hA5C3);
        chk("rd_len", last_rd_len, 16);
        chk("rd_addr", rise_addr, 22'h000100);
        cnt_ok = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge mclk);
            #1;
            if (!ram_read && !ram_write) cnt_ok++;
        end
        chk("rd_recov_low", cnt_ok, 4);
        wait_idle();

        // posted word write, then byte write
        do_req(1, 0, 22'h000200, 16'h1234, 0, lat);
        chk("wr_lat", lat, 1);
        wait_idle();
        chk("wr_len", last_wr_len, 16);
        chk("wr_addr", rise_addr, 22'h000200);
        chk("wr_data", rise_wdata, 16'h1234);
        chk("wr_byte0", rise_byte, 0);
        do_req(1, 1, 22'h000201, 16'h00AB, 0, lat);
        wait_idle();
        chk("wr_byte1", rise_byte, 1);

        // write followed immediately by read of the same address
        ram_rdata = 16'h5A5A;
        do_req(1, 0, 22'h000300, 16'hBEEF, 1, lat);
        do_req(0, 0, 22'h000300, 16'h0, 0, lat);
        chk("wr_rd_lat", lat, 38);
        chk("wr_rd_gap", last_gap, RECOVER + 1);
        chk("wr_rd_data", cpu_rdata, 16'h5A5A);
        chk("wr_rd_addr", rise_addr, 22'h000300);
        wait_idle();

        // back-to-back writes
        do_req(1, 0, 22'h000400, 16'h1111, 1, lat);
        do_req(1, 0, 22'h000402, 16'h2222, 0, lat2);
        chk("b2b_lat1", lat, 1);
        chk("b2b_lat2", lat2, 18);
        chk("b2b_first_rise", rise_wdata, 16'h1111);
        chk("b2b_first_fall", fall_wdata, 16'h1111);
        wait_idle();
        chk("b2b_second", rise_wdata, 16'h2222);

        // init low holds off a pending byte read
        init = 0; ram_rdata = 16'h0F0F;
        cpu_req = 1; cpu_we = 0; cpu_byte = 1; cpu_addr = 22'h000123;
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge mclk);
            #1;
            if (ram_read) hits++;
        end
        chk("init_hold", hits, 0);
        init = 1;
        @(negedge mclk);
        #1;
        chk("init_go", ram_read, 1);
        chk("init_byte", ram_byte, 0);
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge mclk);
            #1;
            if (cpu_ack) begin lat = i; break; end
        end
        chk("init_lat", lat, 16);
        chk("init_data", cpu_rdata, 16'h0F0F);
        cpu_req = 0;
        wait_idle();

        // reset in the middle of a write strobe
        do_req(1, 0, 22'h000500, 16'h3333, 0, lat);
        hits = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge mclk);
            #1;
            if (ram_write) hits++;
            if (hits == 8) break;
        end
        chk("mid_wr_reached", hits, 8);
        rst_n = 0;
        #1;
        chk("arst_write", ram_write, 0);
        chk("arst_busy", busy, 0);
        chk("arst_addr", ram_addr, 0);
        repeat (2) @(negedge mclk);
        rst_n = 1;
        #1;
        ram_rdata = 16'hC0DE;
        do_req(0, 0, 22'h000600, 16'h0, 0, lat);
        chk("post_rst_lat", lat, 17);
        chk("post_rst_data", cpu_rdata, 16'hC0DE);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
